// File: rtl/sdram_pkg.sv
// Shared SDRAM controller types: command pin encodings, mode register value,
// controller state encoding and the wait-counter helper.
package sdram_pkg;

   // {CS_N, RAS_N, CAS_N, WE_N}
   typedef enum logic [3:0] {
      CMD_LOAD_MODE = 4'b0000,
      CMD_REFRESH   = 4'b0001,
      CMD_PRECHARGE = 4'b0010,
      CMD_ACTIVE    = 4'b0011,
      CMD_WRITE     = 4'b0100,
      CMD_READ      = 4'b0101,
      CMD_NOP       = 4'b0111
   } cmd_e;

   // Burst length 1, sequential, CAS latency 2
   localparam logic [12:0] MODE_REG = 13'h020;
   localparam int          CNT_W    = 16;

   typedef enum logic [4:0] {
      ST_WAIT, ST_PRE, ST_TRP, ST_REF1, ST_RFC1, ST_REF2, ST_RFC2, ST_LMR, ST_MRD,
      ST_IDLE, ST_AREF, ST_ARFC,
      ST_ACT_W, ST_RCD_W, ST_WRITE, ST_WR_WAIT,
      ST_ACT_R, ST_RCD_R, ST_READ, ST_CAS, ST_RD_RP
   } state_e;

   // A wait state entered with cnt = 0 is done after `cycles` clocks
   function automatic logic wait_done(input logic [CNT_W-1:0] cnt, input int cycles);
      return cnt == CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/sdram_if.sv
// SDRAM command/address pins; the controller drives them through the master modport.
interface sdram_if;
   logic [12:0] DRAM_ADDR;
   logic [1:0]  DRAM_BA;
   logic [1:0]  DRAM_DQM;
   logic        DRAM_CKE;
   logic        DRAM_CLK;
   logic        DRAM_CS_N;
   logic        DRAM_RAS_N;
   logic        DRAM_CAS_N;
   logic        DRAM_WE_N;

   modport master (
      output DRAM_ADDR, DRAM_BA, DRAM_DQM, DRAM_CKE, DRAM_CLK,
             DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N
   );
   modport slave (
      input  DRAM_ADDR, DRAM_BA, DRAM_DQM, DRAM_CKE, DRAM_CLK,
             DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N
   );
endinterface

// File: rtl/sdram_refresh_timer.sv
// Auto-refresh interval timer: starts on first IDLE entry, raises a sticky
// pending flag every REF_INTERVAL clocks and restarts when a REFRESH is issued.
module sdram_refresh_timer #(
   parameter int REF_INTERVAL = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic clr,
   output logic pending
);
   logic        run_r;
   logic [15:0] cnt_r;
   logic        pending_r;

   // Interval counter and pending flag
   always_ff @(posedge clk) begin
      if (reset) begin
         run_r     <= 1'b0;
         cnt_r     <= 16'd0;
         pending_r <= 1'b0;
      end else if (start || clr) begin
         run_r     <= 1'b1;
         cnt_r     <= 16'd0;
         pending_r <= 1'b0;
      end else if (run_r) begin
         if (cnt_r == 16'(REF_INTERVAL - 1)) begin
            cnt_r     <= 16'd0;
            pending_r <= 1'b1;
         end else begin
            cnt_r <= cnt_r + 16'd1;
         end
      end
   end

   assign pending = pending_r;
endmodule

// File: rtl/sdram.sv
// SDRAM controller with power-up init, periodic auto-refresh and a write/read-back
// traffic generator that counts data mismatches.
module sdram
   import sdram_pkg::*;
#(
   parameter int INIT_CYCLES  = 200,
   parameter int REF_INTERVAL = 7,
   parameter int T_RP         = 1,
   parameter int T_RFC        = 1,
   parameter int T_MRD        = 2,
   parameter int T_RCD        = 1,
   parameter int CAS_LAT      = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   sdram_if.master     dram,
   inout  wire  [15:0] DRAM_DQ
);
   state_e             state_r, state_n;
   logic [CNT_W-1:0]   cnt_r, cnt_n;
   cmd_e               cmd_r, cmd_s;
   logic [1:0]         ba_r, ba_s;
   logic [12:0]        addr_pin_r, addr_s;
   logic               cke_r, dq_oe_r, dq_oe_s;
   logic [15:0]        dq_out_r;
   logic [24:0]        addr_r;
   logic [15:0]        err_cnt_r;
   logic               timer_start_s, ref_clr_s, ref_pend_s, capture_s, inc_s;

   sdram_refresh_timer #(.REF_INTERVAL(REF_INTERVAL)) u_refresh_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (timer_start_s),
      .clr     (ref_clr_s),
      .pending (ref_pend_s)
   );

   // Next state, then pin values for the state being entered
   always_comb begin
      state_n       = state_r;
      timer_start_s = 1'b0;
      ref_clr_s     = 1'b0;
      capture_s     = 1'b0;
      inc_s         = 1'b0;
      case (state_r)
         // The reset cycle leaves cnt at 0, so INIT_CYCLES NOPs follow release
         ST_WAIT:    state_n = (cnt_r == CNT_W'(INIT_CYCLES)) ? ST_PRE : ST_WAIT;
         ST_PRE:     state_n = ST_TRP;
         ST_TRP:     state_n = wait_done(cnt_r, T_RP)  ? ST_REF1 : ST_TRP;
         ST_REF1:    state_n = ST_RFC1;
         ST_RFC1:    state_n = wait_done(cnt_r, T_RFC) ? ST_REF2 : ST_RFC1;
         ST_REF2:    state_n = ST_RFC2;
         ST_RFC2:    state_n = wait_done(cnt_r, T_RFC) ? ST_LMR : ST_RFC2;
         ST_LMR:     state_n = ST_MRD;
         ST_MRD: begin
            state_n       = wait_done(cnt_r, T_MRD) ? ST_IDLE : ST_MRD;
            timer_start_s = wait_done(cnt_r, T_MRD);
         end
         ST_IDLE: begin
            if (ref_pend_s) begin
               state_n   = ST_AREF;
               ref_clr_s = 1'b1;
            end else begin
               state_n = en ? ST_ACT_W : ST_IDLE;
            end
         end
         ST_AREF:    state_n = ST_ARFC;
         ST_ARFC:    state_n = wait_done(cnt_r, T_RFC) ? ST_IDLE : ST_ARFC;
         ST_ACT_W:   state_n = ST_RCD_W;
         ST_RCD_W:   state_n = wait_done(cnt_r, T_RCD) ? ST_WRITE : ST_RCD_W;
         ST_WRITE:   state_n = ST_WR_WAIT;
         ST_WR_WAIT: state_n = wait_done(cnt_r, T_RP + 1) ? ST_ACT_R : ST_WR_WAIT;
         ST_ACT_R:   state_n = ST_RCD_R;
         ST_RCD_R:   state_n = wait_done(cnt_r, T_RCD) ? ST_READ : ST_RCD_R;
         ST_READ:    state_n = ST_CAS;
         ST_CAS: begin
            state_n   = wait_done(cnt_r, CAS_LAT) ? ST_RD_RP : ST_CAS;
            capture_s = wait_done(cnt_r, CAS_LAT);
         end
         ST_RD_RP: begin
            state_n = wait_done(cnt_r, T_RP) ? ST_IDLE : ST_RD_RP;
            inc_s   = wait_done(cnt_r, T_RP);
         end
         default:    state_n = ST_WAIT;
      endcase

      cnt_n   = (state_n == state_r) ? cnt_r + CNT_W'(1) : {CNT_W{1'b0}};
      cmd_s   = CMD_NOP;
      ba_s    = 2'b00;
      addr_s  = 13'd0;
      dq_oe_s = 1'b0;
      case (state_n)
         ST_PRE: begin
            cmd_s  = CMD_PRECHARGE;
            addr_s = 13'h0400;
         end
         ST_REF1, ST_REF2, ST_AREF: cmd_s = CMD_REFRESH;
         ST_LMR: begin
            cmd_s  = CMD_LOAD_MODE;
            addr_s = MODE_REG;
         end
         ST_ACT_W, ST_ACT_R: begin
            cmd_s  = CMD_ACTIVE;
            ba_s   = addr_r[24:23];
            addr_s = addr_r[22:10];
         end
         // A10 set on column commands selects auto-precharge
         ST_WRITE: begin
            cmd_s   = CMD_WRITE;
            ba_s    = addr_r[24:23];
            addr_s  = {2'b00, 1'b1, addr_r[9:0]};
            dq_oe_s = 1'b1;
         end
         ST_READ: begin
            cmd_s  = CMD_READ;
            ba_s   = addr_r[24:23];
            addr_s = {2'b00, 1'b1, addr_r[9:0]};
         end
         default: cmd_s = CMD_NOP;
      endcase
   end

   // State register and registered SDRAM pins
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_WAIT;
         cnt_r      <= {CNT_W{1'b0}};
         cmd_r      <= CMD_NOP;
         ba_r       <= 2'b00;
         addr_pin_r <= 13'd0;
         cke_r      <= 1'b0;
         dq_oe_r    <= 1'b0;
         dq_out_r   <= 16'd0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         cmd_r      <= cmd_s;
         ba_r       <= ba_s;
         addr_pin_r <= addr_s;
         cke_r      <= 1'b1;
         dq_oe_r    <= dq_oe_s;
         dq_out_r   <= addr_r[15:0];
      end
   end

   // Traffic address and saturating read-back error counter
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_r    <= 25'd0;
         err_cnt_r <= 16'd0;
      end else begin
         if (inc_s) begin
            addr_r <= addr_r + 25'd1;
         end
         if (capture_s && (DRAM_DQ != addr_r[15:0]) && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_r <= err_cnt_r + 16'd1;
         end
      end
   end

   assign dram.DRAM_ADDR  = addr_pin_r;
   assign dram.DRAM_BA    = ba_r;
   assign dram.DRAM_DQM   = 2'b00;
   assign dram.DRAM_CKE   = cke_r;
   assign dram.DRAM_CLK   = ~clk;
   assign {dram.DRAM_CS_N, dram.DRAM_RAS_N, dram.DRAM_CAS_N, dram.DRAM_WE_N} = cmd_r;
   assign DRAM_DQ = dq_oe_r ? dq_out_r : 16'bz;
endmodule

// File: tb/tb_sdram.sv
// Randomised bench for sdram: a command-sequence reference model predicts every
// pin cycle, and a bank/row memory model answers reads on DQ.
module tb_sdram;
   localparam int INIT_CYCLES = 200, REF_INTERVAL = 7, T_RP = 1, T_RFC = 1;
   localparam int T_MRD = 2, T_RCD = 1, CAS_LAT = 2;
   localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
   localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;

   typedef struct packed {
      logic        cke;
      logic [3:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] addr;
      logic        oe;
      logic [15:0] dq;
      logic        idle;
   } item_t;

   logic        clk = 1'b0;
   logic        reset, en;
   wire  [15:0] DRAM_DQ;
   logic [15:0] tb_dq;
   logic        tb_dq_oe;

   int          vectors = 0, miscompares = 0;
   item_t       q[$];
   item_t       exp_p;
   int          n = 0, due = 0;
   bit          timer_on, need_init, first_idle, prev_idle;
   logic [24:0] m_addr;
   int          exp_err;
   logic [15:0] mem [logic [24:0]];
   logic [12:0] row_open [4];
   bit          rd_active, corrupt_mode, hit;
   int          rd_age;
   logic [3:0]  obs_cmd;

   sdram_if dram();
   sdram #(
      .INIT_CYCLES(INIT_CYCLES), .REF_INTERVAL(REF_INTERVAL), .T_RP(T_RP), .T_RFC(T_RFC),
      .T_MRD(T_MRD), .T_RCD(T_RCD), .CAS_LAT(CAS_LAT)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .dram(dram), .DRAM_DQ(DRAM_DQ)
   );

   assign DRAM_DQ = tb_dq_oe ? tb_dq : 16'bz;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, n);
      end
   endtask

   function automatic item_t mk(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                                input logic oe, input logic [15:0] d);
      item_t it;
      it.cke = 1'b1; it.cmd = c; it.ba = b; it.addr = a; it.oe = oe; it.dq = d; it.idle = 1'b0;
      return it;
   endfunction

   task automatic push_nops(input int k);
      for (int i = 0; i < k; i++) q.push_back(mk(C_NOP, 2'd0, 13'd0, 1'b0, 16'd0));
   endtask

   task automatic push_init();
      push_nops(INIT_CYCLES);
      q.push_back(mk(C_PRE, 2'd0, 13'h0400, 1'b0, 16'd0));
      push_nops(T_RP);
      q.push_back(mk(C_REF, 2'd0, 13'd0, 1'b0, 16'd0));
      push_nops(T_RFC);
      q.push_back(mk(C_REF, 2'd0, 13'd0, 1'b0, 16'd0));
      push_nops(T_RFC);
      q.push_back(mk(C_LMR, 2'd0, 13'h020, 1'b0, 16'd0));
      push_nops(T_MRD);
   endtask

   task automatic push_access();
      logic [1:0]  b;
      logic [12:0] col;
      b   = m_addr[24:23];
      col = {2'b00, 1'b1, m_addr[9:0]};
      q.push_back(mk(C_ACT, b, m_addr[22:10], 1'b0, 16'd0));
      push_nops(T_RCD);
      q.push_back(mk(C_WR, b, col, 1'b1, m_addr[15:0]));
      push_nops(T_RP + 1);
      q.push_back(mk(C_ACT, b, m_addr[22:10], 1'b0, 16'd0));
      push_nops(T_RCD);
      q.push_back(mk(C_RD, b, col, 1'b0, 16'd0));
      push_nops(CAS_LAT + T_RP);
      m_addr = m_addr + 25'd1;
   endtask

   // Predict the pins for the next cycle from the inputs applied at the coming edge
   task automatic model_step(input logic r, input logic e);
      n++;
      if (r) begin
         q.delete();
         exp_p = '0;
         exp_p.cmd = C_NOP;
         m_addr = 25'd0; exp_err = 0;
         timer_on = 1'b0; need_init = 1'b1; prev_idle = 1'b0; first_idle = 1'b0;
         return;
      end
      if (need_init) begin
         push_init();
         need_init = 1'b0; first_idle = 1'b1;
      end
      if (q.size() == 0 && prev_idle) begin
         if (timer_on && (n - 1) >= due) begin
            q.push_back(mk(C_REF, 2'd0, 13'd0, 1'b0, 16'd0));
            push_nops(T_RFC);
            due = n + REF_INTERVAL;
         end else if (e) begin
            push_access();
         end
      end
      if (q.size() > 0) begin
         exp_p = q.pop_front();
         prev_idle = 1'b0;
      end else begin
         exp_p = mk(C_NOP, 2'd0, 13'd0, 1'b0, 16'd0);
         exp_p.idle = 1'b1;
         if (first_idle) begin
            first_idle = 1'b0; timer_on = 1'b1; due = n + REF_INTERVAL;
         end
         prev_idle = 1'b1;
      end
   endtask

   // One clock: check this cycle, run the memory model, apply inputs for the next edge
   task automatic step(input logic r, input logic e);
      logic [24:0] key;
      @(negedge clk);
      #1;
      obs_cmd = {dram.DRAM_CS_N, dram.DRAM_RAS_N, dram.DRAM_CAS_N, dram.DRAM_WE_N};
      check("pins", {dram.DRAM_CLK, dram.DRAM_CKE, obs_cmd, dram.DRAM_BA, dram.DRAM_ADDR, dram.DRAM_DQM},
            {1'b1, exp_p.cke, exp_p.cmd, exp_p.ba, exp_p.addr, 2'b00});
      check("dq_oe", {31'd0, dut.dq_oe_r}, {31'd0, exp_p.oe});
      if (exp_p.oe) check("wdata", {16'd0, DRAM_DQ}, {16'd0, exp_p.dq});
      if (exp_p.idle) begin
         check("addr", {7'd0, dut.addr_r}, {7'd0, m_addr});
         check("errcnt", {16'd0, dut.err_cnt_r}, 32'(exp_err));
      end
      if (rd_active) begin
         rd_age++;
         tb_dq_oe = (rd_age >= 1) && (rd_age <= CAS_LAT);
         if (rd_age > CAS_LAT) rd_active = 1'b0;
      end
      if (obs_cmd == C_ACT) row_open[dram.DRAM_BA] = dram.DRAM_ADDR;
      key = {dram.DRAM_BA, row_open[dram.DRAM_BA], dram.DRAM_ADDR[9:0]};
      if (obs_cmd == C_WR) mem[key] = DRAM_DQ;
      if (obs_cmd == C_RD) begin
         rd_active = 1'b1; rd_age = 0;
         tb_dq = mem.exists(key) ? mem[key] : 16'h0000;
         if (corrupt_mode && $urandom_range(0, 1) == 1) begin
            tb_dq = tb_dq ^ 16'($urandom_range(1, 65535));
            exp_err++;
         end
      end
      if (r) begin
         rd_active = 1'b0; tb_dq_oe = 1'b0;
      end
      reset = r;
      en    = e;
      model_step(r, e);
   endtask

   initial begin
      tb_dq = 16'd0; tb_dq_oe = 1'b0; corrupt_mode = 1'b0; rd_active = 1'b0; rd_age = 0;
      for (int i = 0; i < 4; i++) row_open[i] = 13'd0;
      reset = 1'b1; en = 1'b1;
      model_step(1'b1, 1'b1);
      // Init with en toggling, then a quiet window where only refreshes may appear
      for (int i = 0; i < 205; i++) step(1'b0, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++)  step(1'b0, 1'b0);
      for (int i = 0; i < 400; i++) step(1'b0, 1'($urandom_range(0, 7) != 0));
      corrupt_mode = 1'b1;
      for (int i = 0; i < 250; i++) step(1'b0, 1'($urandom_range(0, 3) != 0));
      corrupt_mode = 1'b0;
      for (int i = 0; i < 20; i++)  step(1'b0, 1'b0);
      // Top-of-range address: bank 3, row 1FFF, col 3FF, then wrap to 0
      force dut.addr_r = 25'h1FFFFFF;
      m_addr = 25'h1FFFFFF;
      step(1'b0, 1'b0);
      release dut.addr_r;
      step(1'b0, 1'b0);
      for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
      // Reset in the middle of a write access, then a full re-init
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         step(1'b0, 1'b1);
         if (obs_cmd == C_WR) hit = 1'b1;
      end
      check("write_seen", {31'd0, hit}, 32'd1);
      step(1'b1, 1'b1);
      for (int i = 0; i < 300; i++) step(1'b0, 1'($urandom_range(0, 3) != 0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
